glitch_generator: RTL and testbench
===================================

GLITCH_GENERATOR -- requirements
Module: glitch_generator

Interface
REQ-001 SHALL have the port: clk  input  1  rising-edge clock.
REQ-002 SHALL have the port: rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have the port: start  input  1  begin a burst; sampled only in IDLE.
REQ-004 SHALL have the port: abort  input  1  terminate the burst; highest priority after reset.
REQ-005 SHALL have the port: base  input  4  stable pattern level; latched on an accepted start.
REQ-006 SHALL have the port: mask  input  4  XOR mask applied during a glitch cycle; latched on start.
REQ-007 SHALL have the port: target  input  8  number of glitches to emit; latched on start.
REQ-008 SHALL have the port: gap  input  4  stable cycles before each glitch; latched on start.
REQ-009 SHALL have the port: out_data  output  4  generated pattern, driven to the analyzer input under test.
REQ-010 SHALL have the port: sent  output  8  glitches emitted in the current or last burst.
REQ-011 SHALL have the port: busy  output  1  high in HOLD, PULSE and DRAIN.
REQ-012 SHALL have the port: done  output  1  one-cycle completion pulse.

Function
REQ-013 SHALL register all outputs, with no combinational path from any input to any output.
REQ-014 SHALL define a glitch as one cycle of out_data = base^mask, preceded by at least 2 cycles of out_data = base and followed by at least 2 cycles of out_data = base.
REQ-015 SHALL use effective gap G = max(gap, 2) and effective mask M = (mask==0) ? 4'b0001 : mask.
REQ-016 SHALL implement the states IDLE, HOLD, PULSE, DRAIN and DONE.
REQ-017 In IDLE, start=1 SHALL latch base, M, target and G, clear sent, and enter HOLD with the timer set to G; if target==0 it SHALL enter DONE instead.
REQ-018 In IDLE, start=0 SHALL hold state.
REQ-019 In HOLD, out_data SHALL equal base for exactly G cycles, after which the FSM SHALL enter PULSE.
REQ-020 In PULSE, out_data SHALL equal base^M for exactly 1 cycle and sent SHALL increment by 1 on exit.
REQ-021 On PULSE exit, the FSM SHALL enter DRAIN if the new sent == target; otherwise it SHALL re-enter HOLD with the timer reloaded to G.
REQ-022 In DRAIN, out_data SHALL equal base for 2 cycles, after which the FSM SHALL enter DONE.
REQ-023 In DONE, done SHALL be 1 for exactly 1 cycle, after which the FSM SHALL return to IDLE; out_data SHALL remain base.
REQ-024 Timing: with an accepted start at edge N, the first glitch SHALL appear at cycle N+G+1, and done SHALL assert K*(G+1)+3 cycles after N for K=target>0, or at cycle N+1 for target=0.
REQ-025 start asserted while not in IDLE SHALL be ignored, and the latched parameters SHALL NOT change mid-burst.
REQ-026 abort=1 in any non-IDLE state SHALL enter IDLE on the next edge with out_data = base, done=0, busy=0, and sent frozen.
REQ-027 If abort and start are both 1 in IDLE, abort SHALL win and no burst SHALL start.
REQ-028 sent SHALL never exceed target and SHALL never wrap.
REQ-029 In IDLE, out_data SHALL hold the last latched base.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE with out_data=0, sent=0, busy=0 and done=0, and clear all latched parameters and the timer.
REQ-031 Reset asserted mid-burst SHALL abandon the burst with no done pulse, and the first edge after release SHALL behave as IDLE.

Structure
REQ-032 The shared package SHALL hold the state-encoding typedef, MIN_GAP=2, DRAIN_CYCLES=2 and DEFAULT_MASK=4'b0001.
REQ-033 The block SHALL be a single module with no sub-module; the gap timer SHALL be an inline 4-bit down-counter.

Verification
REQ-034 Bench SHALL cover: base=4'h3, mask=4'h4, target=3, gap=4, start -> out_data 3,3,3,3,7 repeated 3 times, then 3,3; done at cycle 18; sent=3; a glitch counter fed from out_data reads 3.
REQ-035 Bench SHALL cover: gap=0, mask=0, base=0, target=2 -> G=2, M=1; out_data 0,0,1,0,0,1,0,0; done at cycle 9.
REQ-036 Bench SHALL cover: target=0, start -> done at cycle 1, busy never set, out_data never glitches, sent=0.
REQ-037 Bench SHALL cover: target=255, gap=2 -> sent ends at 255 with no wrap, and done at cycle 255*3+3=768.
REQ-038 Bench SHALL cover: abort asserted during the 2nd PULSE with target=5 -> IDLE next edge, sent=1, no done, out_data=base; a subsequent start runs normally.
REQ-039 Bench SHALL cover: rst_n asserted mid-HOLD -> immediate out_data=0, busy=0, sent=0, and start mid-burst ignored (parameters unchanged, timing per REQ-024).

Source files
------------

// File: rtl/glitch_generator_pkg.sv
// Shared definitions for the glitch generator: state encoding, timing constants
// and the helpers that turn raw gap/mask inputs into their effective values.
package glitch_generator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HOLD,
      ST_PULSE,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam logic [3:0] MIN_GAP      = 4'd2;
   localparam logic [3:0] DRAIN_CYCLES = 4'd2;
   localparam logic [3:0] DEFAULT_MASK = 4'b0001;

   // A glitch needs at least MIN_GAP stable cycles around it, and a zero mask
   // would produce no glitch at all, so both are clamped.
   function automatic logic [3:0] eff_gap(input logic [3:0] g);
      return (g < MIN_GAP) ? MIN_GAP : g;
   endfunction

   function automatic logic [3:0] eff_mask(input logic [3:0] m);
      return (m == 4'd0) ? DEFAULT_MASK : m;
   endfunction

endpackage

// File: rtl/glitch_generator.sv
// Emits bursts of single-cycle glitches (base^mask) separated by stable base
// cycles; used to exercise a downstream pattern analyzer.
module glitch_generator
   import glitch_generator_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [3:0] base,
   input  logic [3:0] mask,
   input  logic [7:0] target,
   input  logic [3:0] gap,
   output logic [3:0] out_data,
   output logic [7:0] sent,
   output logic       busy,
   output logic       done
);

   // start is a level sampled only in IDLE (a request, no ready back); abort
   // overrides everything except reset and returns to IDLE on the next edge.
   state_e     state_q, state_d;
   logic [3:0] timer_q, timer_d;
   logic [3:0] base_q, base_d;
   logic [3:0] mask_q, mask_d;
   logic [3:0] gap_q, gap_d;
   logic [7:0] target_q, target_d;
   logic [7:0] sent_q, sent_d;
   logic [3:0] out_q, out_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         timer_q  <= 4'd0;
         base_q   <= 4'd0;
         mask_q   <= 4'd0;
         gap_q    <= 4'd0;
         target_q <= 8'd0;
         sent_q   <= 8'd0;
         out_q    <= 4'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         base_q   <= base_d;
         mask_q   <= mask_d;
         gap_q    <= gap_d;
         target_q <= target_d;
         sent_q   <= sent_d;
         out_q    <= out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      base_d   = base_q;
      mask_d   = mask_q;
      gap_d    = gap_q;
      target_d = target_q;
      sent_d   = sent_q;

      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               base_d   = base;
               mask_d   = eff_mask(mask);
               gap_d    = eff_gap(gap);
               target_d = target;
               sent_d   = 8'd0;
               if (target == 8'd0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_HOLD;
                  timer_d = eff_gap(gap);
               end
            end
         end
         ST_HOLD: begin
            if (timer_q <= 4'd1) state_d = ST_PULSE;
            else                 timer_d = timer_q - 4'd1;
         end
         ST_PULSE: begin
            sent_d = sent_q + 8'd1;
            if (sent_d == target_q) begin
               state_d = ST_DRAIN;
               timer_d = DRAIN_CYCLES;
            end else begin
               state_d = ST_HOLD;
               timer_d = gap_q;
            end
         end
         ST_DRAIN: begin
            if (timer_q <= 4'd1) state_d = ST_DONE;
            else                 timer_d = timer_q - 4'd1;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         sent_d  = sent_q;
      end

      // Outputs are derived from the next state so they register alongside it.
      out_d  = (state_d == ST_PULSE) ? (base_d ^ mask_d) : base_d;
      busy_d = (state_d == ST_HOLD) || (state_d == ST_PULSE) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
   end

   assign out_data = out_q;
   assign sent     = sent_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_glitch_generator.sv
// Directed bench for glitch_generator: bursts push their expected per-cycle
// trace into a queue, and a negedge monitor pops and compares every cycle.
module tb_glitch_generator;

   localparam int W = 14;  // {out_data[3:0], busy, done, sent[7:0]}

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] base = 4'd0;
   logic [3:0] mask = 4'd0;
   logic [3:0] gap = 4'd0;
   logic [7:0] target = 8'd0;
   logic [3:0] out_data;
   logic [7:0] sent;
   logic       busy;
   logic       done;

   always #5 clk = ~clk;

   glitch_generator dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .base     (base),
      .mask     (mask),
      .target   (target),
      .gap      (gap),
      .out_data (out_data),
      .sent     (sent),
      .busy     (busy),
      .done     (done)
   );

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_exp;
   int mon_checks = 0;
   int mon_fails  = 0;
   int drv_checks = 0;
   int drv_fails  = 0;
   int cycle_cnt  = 0;
   int last_done  = -1;
   int glitch_cnt = 0;
   logic [3:0] tb_base = 4'd0;
   int t_start = 0;
   int g0 = 0;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   // Monitor: one expected record per cycle while the queue holds any.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_checks++;
         if ({out_data, busy, done, sent} !== mon_exp) begin
            mon_fails++;
            $display("FAIL trace @%0t: got out=%h busy=%b done=%b sent=%0d, expected out=%h busy=%b done=%b sent=%0d",
                     $time, out_data, busy, done, sent,
                     mon_exp[13:10], mon_exp[9], mon_exp[8], mon_exp[7:0]);
         end
      end
   end

   // Done-cycle recorder and a glitch counter fed from out_data.
   always @(negedge clk) begin
      if (done === 1'b1) last_done = cycle_cnt;
      if (rst_n && (out_data !== tb_base)) glitch_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic chk(input string name, input int act, input int expv);
      drv_checks++;
      if (act != expv) begin
         drv_fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic push_rec(input logic [3:0] o, input logic b, input logic d, input logic [7:0] s);
      exp_q.push_back({o, b, d, s});
   endtask

   // Expected trace for a full burst, from the effective gap/mask definitions.
   task automatic push_burst(input logic [3:0] b, input logic [3:0] m,
                             input logic [7:0] k, input logic [3:0] g);
      logic [3:0] ge, me;
      ge = (g < 4'd2) ? 4'd2 : g;
      me = (m == 4'd0) ? 4'd1 : m;
      if (k == 8'd0) begin
         push_rec(b, 1'b0, 1'b1, 8'd0);
      end else begin
         for (int i = 0; i < int'(k); i++) begin
            for (int j = 0; j < int'(ge); j++) push_rec(b, 1'b1, 1'b0, 8'(i));
            push_rec(b ^ me, 1'b1, 1'b0, 8'(i));
         end
         push_rec(b, 1'b1, 1'b0, k);
         push_rec(b, 1'b1, 1'b0, k);
         push_rec(b, 1'b0, 1'b1, k);
      end
      push_rec(b, 1'b0, 1'b0, k);
   endtask

   // Returns #2 after the accepting edge; inputs are scrambled afterwards so
   // any failure to latch shows up in the trace.
   task automatic issue_start(input logic [3:0] b, input logic [3:0] m,
                              input logic [7:0] k, input logic [3:0] g, input bit do_push);
      @(posedge clk); #2;
      base = b; mask = m; target = k; gap = g; start = 1'b1;
      @(posedge clk); #2;
      start  = 1'b0;
      base   = 4'($urandom_range(0, 15));
      mask   = 4'($urandom_range(0, 15));
      target = 8'($urandom_range(0, 255));
      gap    = 4'($urandom_range(0, 15));
      tb_base = b;
      g0      = glitch_cnt;
      t_start = cycle_cnt;
      if (do_push) push_burst(b, m, k, g);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      #2;
      if (exp_q.size() != 0) begin
         drv_checks++;
         drv_fails++;
         $display("FAIL %s_timeout: %0d records left, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic run_burst(input string name, input logic [3:0] b, input logic [3:0] m,
                            input logic [7:0] k, input logic [3:0] g,
                            input int exp_lat, input int exp_gl);
      issue_start(b, m, k, g, 1'b1);
      wait_drain(name);
      chk({name, "_done_cycle"}, last_done - t_start + 1, exp_lat);
      chk({name, "_glitches"}, glitch_cnt - g0, exp_gl);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #12;
      chk("rst_out", int'(out_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_sent", int'(sent), 0);
      @(posedge clk); #2;
      rst_n = 1'b1;

      run_burst("basic",   4'h3, 4'h4, 8'd3,   4'd4, 18,  3);
      run_burst("clamp",   4'h0, 4'h0, 8'd2,   4'd0, 9,   2);
      run_burst("zero",    4'h7, 4'h5, 8'd0,   4'd6, 1,   0);
      run_burst("max",     4'hA, 4'hC, 8'd255, 4'd2, 768, 255);

      // Abort during the second PULSE of a 5-glitch burst.
      issue_start(4'h5, 4'h3, 8'd5, 4'd2, 1'b0);
      push_rec(4'h5, 1'b1, 1'b0, 8'd0);
      push_rec(4'h5, 1'b1, 1'b0, 8'd0);
      push_rec(4'h6, 1'b1, 1'b0, 8'd0);
      push_rec(4'h5, 1'b1, 1'b0, 8'd1);
      push_rec(4'h5, 1'b1, 1'b0, 8'd1);
      push_rec(4'h6, 1'b1, 1'b0, 8'd1);
      push_rec(4'h5, 1'b0, 1'b0, 8'd1);
      push_rec(4'h5, 1'b0, 1'b0, 8'd1);
      repeat (5) @(posedge clk);
      #2 abort = 1'b1;
      @(posedge clk); #2;
      abort = 1'b0;
      wait_drain("abort");
      chk("abort_no_done", int'(last_done >= t_start), 0);
      run_burst("after_abort", 4'h5, 4'h3, 8'd1, 4'd2, 6, 1);

      // abort and start together in IDLE: nothing starts.
      @(posedge clk); #2;
      start = 1'b1; abort = 1'b1; base = 4'hF; mask = 4'h2; target = 8'd4; gap = 4'd3;
      @(posedge clk); #2;
      start = 1'b0; abort = 1'b0;
      t_start = cycle_cnt;
      repeat (3) push_rec(4'h5, 1'b0, 1'b0, 8'd1);
      wait_drain("abort_start");
      chk("abort_start_no_done", int'(last_done >= t_start), 0);

      // start re-asserted mid-burst with different parameters is ignored.
      issue_start(4'hA, 4'hF, 8'd2, 4'd3, 1'b1);
      repeat (2) @(posedge clk);
      #2;
      start = 1'b1; base = 4'h0; mask = 4'h1; target = 8'd9; gap = 4'd7;
      @(posedge clk); #2;
      start = 1'b0;
      wait_drain("midstart");
      chk("midstart_done_cycle", last_done - t_start + 1, 11);
      chk("midstart_glitches", glitch_cnt - g0, 2);

      // Reset asserted mid-HOLD.
      issue_start(4'h9, 4'h6, 8'd3, 4'd5, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_out", int'(out_data), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_sent", int'(sent), 0);
      chk("midrst_done", int'(done), 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #2;
      chk("postrst_out", int'(out_data), 0);
      chk("postrst_busy", int'(busy), 0);
      chk("postrst_no_done", int'(last_done >= t_start), 0);
      run_burst("post_reset", 4'h1, 4'h2, 8'd1, 4'd0, 6, 1);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               mon_checks + drv_checks, mon_fails + drv_fails);
      $finish;
   end

endmodule
